// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage with IF/ID output register.
//
// Keeps the fetch PC and issues one instruction-memory request at a time over a
// req/gnt/rvalid handshake. Returned words go into the IF/ID register, or into a
// 1-entry skid buffer when decode is stalled. A redirect squashes everything in
// flight. If a request is still outstanding at that point, its response is marked
// for dropping.
//
// Ports:
//   i_clk, i_rst         clock; synchronous active-high reset
//   o_imem_req           fetch request valid
//   o_imem_addr          word-aligned fetch address
//   i_imem_gnt           memory accepts the request this cycle
//   i_imem_rvalid        read data valid, in order, one per grant
//   i_imem_rdata         instruction word
//   i_redirect_valid     redirect the fetch PC (resolved branch/jump)
//   i_redirect_pc        redirect target; bits [1:0] are ignored
//   i_id_ready           decode consumes the IF/ID contents this cycle
//   o_if_valid           IF/ID holds a valid instruction
//   o_if_pc, o_if_instr  PC and instruction word held in IF/ID
//   o_if_opcode          opcode field, zero when IF/ID is empty
module instr_fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_id_ready,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_instr,
  output logic [6:0]      o_if_opcode
);

  typedef enum logic [0:0] {S_REQ, S_WAIT} state_e;

  state_e          r_state,      w_state_nxt;
  logic [XLEN-1:0] r_pc,         w_pc_nxt;
  logic [XLEN-1:0] r_pend_pc,    w_pend_pc_nxt;
  logic            r_drop,       w_drop_nxt;
  logic            r_skid_valid, w_skid_valid_nxt;
  logic [XLEN-1:0] r_skid_pc,    w_skid_pc_nxt;
  logic [31:0]     r_skid_instr, w_skid_instr_nxt;
  logic            r_if_valid,   w_if_valid_nxt;
  logic [XLEN-1:0] r_if_pc,      w_if_pc_nxt;
  logic [31:0]     r_if_instr,   w_if_instr_nxt;

  logic w_hs;
  logic w_deliver;
  logic w_slot_free;

  // No new request while the skid is occupied, so there is never a third word to store.
  assign o_imem_req  = !i_rst && (r_state == S_REQ) && !r_skid_valid;
  assign o_imem_addr = r_pc;
  assign w_hs        = o_imem_req && i_imem_gnt;
  assign w_slot_free = !r_if_valid || i_id_ready;
  assign w_deliver   = (r_state == S_WAIT) && i_imem_rvalid && !r_drop;

  assign o_if_valid  = r_if_valid;
  assign o_if_pc     = r_if_pc;
  assign o_if_instr  = r_if_instr;
  assign o_if_opcode = r_if_valid ? r_if_instr[6:0] : 7'b0;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_pc_nxt    = r_pend_pc;
    w_drop_nxt       = r_drop;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_if_valid_nxt   = r_if_valid;
    w_if_pc_nxt      = r_if_pc;
    w_if_instr_nxt   = r_if_instr;

    if (i_redirect_valid) begin
      w_pc_nxt         = {i_redirect_pc[XLEN-1:2], 2'b00};
      w_if_valid_nxt   = 1'b0;
      w_if_instr_nxt   = NOP_INSTR;
      w_skid_valid_nxt = 1'b0;
      unique case (r_state)
        S_REQ: begin
          // A request granted on the redirect edge is still outstanding; squash its reply.
          if (w_hs) begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (w_hs) begin
            w_pend_pc_nxt = r_pc;
            w_pc_nxt      = r_pc + XLEN'(4);
            w_state_nxt   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase

      if (w_deliver) begin
        if (!r_skid_valid && w_slot_free) begin
          w_if_valid_nxt = 1'b1;
          w_if_pc_nxt    = r_pend_pc;
          w_if_instr_nxt = i_imem_rdata;
        end else begin
          w_skid_valid_nxt = 1'b1;
          w_skid_pc_nxt    = r_pend_pc;
          w_skid_instr_nxt = i_imem_rdata;
        end
      end else if (i_id_ready && r_if_valid) begin
        if (r_skid_valid) begin
          w_if_pc_nxt      = r_skid_pc;
          w_if_instr_nxt   = r_skid_instr;
          w_skid_valid_nxt = 1'b0;
        end else begin
          w_if_valid_nxt = 1'b0;
          w_if_instr_nxt = NOP_INSTR;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_pend_pc    <= '0;
      r_drop       <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
      r_if_valid   <= 1'b0;
      r_if_pc      <= '0;
      r_if_instr   <= NOP_INSTR;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_if_pc      <= w_if_pc_nxt;
      r_if_instr   <= w_if_instr_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Testbench for instr_fetch_stage: directed vector table, hand-written redirect/reset
// sequences, then randomized traffic checked against an in-order fetch/consume model.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, gnt, rvalid, redir, rdy;
  logic [31:0] rdata, rpc;
  logic        req, ifv;
  logic [31:0] addr, ifpc, ifinstr;
  logic [6:0]  opc;

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch_stage dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .o_imem_req      (req),
    .o_imem_addr     (addr),
    .i_imem_gnt      (gnt),
    .i_imem_rvalid   (rvalid),
    .i_imem_rdata    (rdata),
    .i_redirect_valid(redir),
    .i_redirect_pc   (rpc),
    .i_id_ready      (rdy),
    .o_if_valid      (ifv),
    .o_if_pc         (ifpc),
    .o_if_instr      (ifinstr),
    .o_if_opcode     (opc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: opcode field is {addr[4:0], 2'b11}.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A00_0000;
  endfunction

  function automatic logic [6:0] opc_of(input logic [31:0] a);
    logic [31:0] w;
    w = memf(a);
    return w[6:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic g, input logic v, input logic [31:0] rd,
                       input logic d, input logic [31:0] rp, input logic y);
    @(negedge clk);
    rst = r; gnt = g; rvalid = v; rdata = rd; redir = d; rpc = rp; rdy = y;
    #1;
  endtask

  typedef struct packed {
    logic        chk;
    logic        rst, gnt, rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] ifpc;
    logic [6:0]  opc;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic r, input logic g, input logic v,
                              input logic [31:0] rd, input logic y, input logic e_req,
                              input logic [31:0] e_addr, input logic e_ifv,
                              input logic [31:0] e_ifpc, input logic [6:0] e_opc);
    vec_t t;
    t = '{chk: c, rst: r, gnt: g, rv: v, rdata: rd, rdy: y, req: e_req, addr: e_addr,
          ifv: e_ifv, ifpc: e_ifpc, opc: e_opc};
    return t;
  endfunction

  vec_t vecs[16];

  // Random-phase model state
  logic        pend;
  int          cnt;
  logic [31:0] paddr, exp_fetch, exp_id;
  logic        prev_stall, prev_redir;
  int          consumed;
  logic        r_r, r_g, r_v, r_d, r_y, hs;
  logic [31:0] r_rp;

  initial begin
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0; redir = 1'b0; rpc = '0; rdy = 1'b0;

    // Reset, 1-cycle memory, then a 6-cycle decode stall filling the skid.
    vecs[0]  = mk(0, 1, 0, 0, 0,           0, 0, 32'h0, 0, 32'h0, 7'h0);
    vecs[1]  = mk(1, 1, 0, 0, 0,           0, 0, 32'h0, 0, 32'h0, 7'h0);
    vecs[2]  = mk(1, 0, 1, 0, 0,           1, 1, 32'h0, 0, 32'h0, 7'h0);
    vecs[3]  = mk(1, 0, 0, 1, memf(32'h0), 1, 0, 32'h4, 0, 32'h0, 7'h0);
    vecs[4]  = mk(1, 0, 1, 0, 0,           1, 1, 32'h4, 1, 32'h0, opc_of(32'h0));
    vecs[5]  = mk(1, 0, 0, 1, memf(32'h4), 1, 0, 32'h8, 0, 32'h0, 7'h0);
    vecs[6]  = mk(1, 0, 1, 0, 0,           0, 1, 32'h8, 1, 32'h4, opc_of(32'h4));
    vecs[7]  = mk(1, 0, 0, 1, memf(32'h8), 0, 0, 32'hC, 1, 32'h4, opc_of(32'h4));
    for (int k = 8; k < 12; k++)
      vecs[k] = mk(1, 0, 1, 0, 0,          0, 0, 32'hC, 1, 32'h4, opc_of(32'h4));
    vecs[12] = mk(1, 0, 0, 0, 0,           1, 0, 32'hC, 1, 32'h4, opc_of(32'h4));
    vecs[13] = mk(1, 0, 1, 0, 0,           1, 1, 32'hC, 1, 32'h8, opc_of(32'h8));
    vecs[14] = mk(1, 0, 0, 1, memf(32'hC), 1, 0, 32'h10, 0, 32'h0, 7'h0);
    vecs[15] = mk(1, 0, 0, 0, 0,           0, 1, 32'h10, 1, 32'hC, opc_of(32'hC));

    for (int k = 0; k < 16; k++) begin
      drive(vecs[k].rst, vecs[k].gnt, vecs[k].rv, vecs[k].rdata, 1'b0, 32'h0, vecs[k].rdy);
      if (vecs[k].chk) begin
        chk($sformatf("vec%0d_req", k), 32'(req), 32'(vecs[k].req));
        chk($sformatf("vec%0d_addr", k), addr, vecs[k].addr);
        chk($sformatf("vec%0d_ifv", k), 32'(ifv), 32'(vecs[k].ifv));
        if (vecs[k].ifv) chk($sformatf("vec%0d_ifpc", k), ifpc, vecs[k].ifpc);
        chk($sformatf("vec%0d_opc", k), 32'(opc), 32'(vecs[k].opc));
        if (k == 1) begin
          chk("reset_ifpc", ifpc, 32'h0);
          chk("reset_ifinstr", ifinstr, NOP);
        end
      end
    end

    // Redirect while waiting; the late response must be squashed.
    drive(0, 1, 0, 0, 0, 0, 1);             chk("rw_addr", addr, 32'h10);
    drive(0, 0, 0, 0, 1, 32'h100, 1);       chk("rw_req0", 32'(req), 0);
    drive(0, 0, 0, 0, 0, 0, 1);             chk("rw_wait_req", 32'(req), 0);
    drive(0, 0, 1, memf(32'h10), 0, 0, 1);  chk("rw_drop_ifv", 32'(ifv), 0);
    drive(0, 1, 0, 0, 0, 0, 1);             chk("rw_next_addr", addr, 32'h100);
                                            chk("rw_stale_ifv", 32'(ifv), 0);
    drive(0, 0, 1, memf(32'h100), 0, 0, 1); chk("rw_ifv_pre", 32'(ifv), 0);
    drive(0, 0, 0, 0, 0, 0, 1);             chk("rw_ifpc", ifpc, 32'h100);
                                            chk("rw_ifv", 32'(ifv), 1);
    // Redirect on the grant edge: unaligned target forced to word boundary.
    drive(0, 1, 0, 0, 1, 32'h203, 1);       chk("rg_addr", addr, 32'h104);
    drive(0, 0, 1, memf(32'h104), 0, 0, 1); chk("rg_req0", 32'(req), 0);
    drive(0, 1, 0, 0, 0, 0, 1);             chk("rg_next_addr", addr, 32'h200);
                                            chk("rg_ifv", 32'(ifv), 0);
    drive(0, 0, 1, memf(32'h200), 0, 0, 0); chk("rg_ifv_pre", 32'(ifv), 0);
    drive(0, 1, 0, 0, 0, 0, 0);             chk("rg_ifpc", ifpc, 32'h200);
                                            chk("rg_addr2", addr, 32'h204);
    drive(0, 0, 1, memf(32'h204), 0, 0, 0); chk("sk_hold_pc", ifpc, 32'h200);
    // Redirect with IF/ID and skid both full.
    drive(0, 1, 0, 0, 1, 32'h300, 1);       chk("sk_req0", 32'(req), 0);
                                            chk("sk_ifv", 32'(ifv), 1);
    drive(0, 0, 0, 0, 0, 0, 1);             chk("sk_flush_ifv", 32'(ifv), 0);
                                            chk("sk_flush_opc", 32'(opc), 0);
                                            chk("sk_addr", addr, 32'h300);
    drive(0, 0, 0, 0, 0, 0, 1);             chk("sk_nostale_ifv", 32'(ifv), 0);
                                            chk("sk_nostale_instr", ifinstr, NOP);
    // Reset in S_WAIT with a response on the same edge.
    drive(0, 1, 0, 0, 0, 0, 1);             chk("rs_addr", addr, 32'h300);
    drive(1, 0, 1, memf(32'h300), 0, 0, 1); chk("rs_req0", 32'(req), 0);
    drive(0, 0, 0, 0, 0, 0, 1);             chk("rs_addr_reset", addr, 32'h0);
                                            chk("rs_req1", 32'(req), 1);
                                            chk("rs_ifv", 32'(ifv), 0);
                                            chk("rs_ifpc", ifpc, 32'h0);
                                            chk("rs_instr", ifinstr, NOP);
    // PC wrap.
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    drive(0, 1, 0, 0, 0, 0, 1);             chk("wr_addr", addr, 32'hFFFF_FFFC);
    drive(0, 0, 1, memf(32'hFFFF_FFFC), 0, 0, 1); chk("wr_addr_wrap", addr, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 1);             chk("wr_ifpc", ifpc, 32'hFFFF_FFFC);
                                            chk("wr_opc", 32'(opc), 32'(opc_of(32'hFFFF_FFFC)));

    // Randomized traffic: fetches must follow PC+4 from the last redirect/reset, and
    // decode must see every such address in order, each with its memory word.
    pend = 1'b0; cnt = 0; paddr = '0; exp_fetch = '0; exp_id = '0;
    prev_stall = 1'b0; prev_redir = 1'b0; consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      r_r  = (i < 2) || ($urandom_range(0, 299) == 0);
      r_v  = !r_r && pend && (cnt == 1);
      r_g  = ($urandom_range(0, 9) < 7);
      r_d  = !r_r && ($urandom_range(0, 29) == 0);
      r_rp = $urandom;
      r_y  = ($urandom_range(0, 9) < 6);
      drive(r_r, r_g, r_v, memf(paddr), r_d, r_rp, r_y);

      if (r_r) chk("rnd_req_in_reset", 32'(req), 0);
      if (pend) chk("rnd_one_outstanding", 32'(req), 0);
      if (!ifv) chk("rnd_idle_instr", ifinstr, NOP);
      if (!ifv) chk("rnd_idle_opc", 32'(opc), 0);
      if (prev_redir) chk("rnd_redirect_flush", 32'(ifv), 0);
      if (prev_stall) begin
        chk("rnd_stall_ifv", 32'(ifv), 1);
        chk("rnd_stall_pc", ifpc, exp_id);
        chk("rnd_stall_instr", ifinstr, memf(exp_id));
      end
      hs = req && r_g && !r_r;
      if (hs) chk("rnd_fetch_addr", addr, exp_fetch);

      if (r_r) begin
        exp_fetch = 32'h0; exp_id = 32'h0; pend = 1'b0;
        prev_stall = 1'b0; prev_redir = 1'b0;
      end else begin
        if (pend) begin
          if (r_v) pend = 1'b0;
          else cnt--;
        end
        if (hs) begin
          exp_fetch = exp_fetch + 32'd4;
          pend = 1'b1; cnt = $urandom_range(1, 3); paddr = addr;
        end
        if (r_d) begin
          exp_fetch = {r_rp[31:2], 2'b00};
          exp_id    = {r_rp[31:2], 2'b00};
        end else if (ifv && r_y) begin
          chk("rnd_consume_pc", ifpc, exp_id);
          chk("rnd_consume_instr", ifinstr, memf(exp_id));
          chk("rnd_consume_opc", 32'(opc), 32'(opc_of(exp_id)));
          exp_id = exp_id + 32'd4;
          consumed++;
        end
        prev_stall = !r_d && ifv && !r_y;
        prev_redir = r_d;
      end
    end
    chk("rnd_progress", 32'(consumed > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
